// File: rtl/tag_control.sv
// CAPI command-tag manager: hands out free tags, keeps per-tag command metadata,
// looks it up on PSL responses and retires tags to a free-list FIFO.
package tag_control_pkg;
  typedef struct packed {
    logic [12:0] com;
    logic [11:0] size;
    logic [63:0] address;
    logic [15:0] ctx;
  } command_tag_line_t;
endpackage

module tag_control
  import tag_control_pkg::*;
#(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = 8
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  input  logic              tag_alloc_req,
  input  command_tag_line_t tag_alloc_cmd,
  output logic              tag_alloc_gnt,
  output logic [TAG_W-1:0]  tag_alloc_tag,
  input  logic              response_valid,
  input  logic [TAG_W-1:0]  response_tag,
  input  logic              response_retain,
  output command_tag_line_t response_tag_id_out,
  output logic [8:0]        tags_in_flight,
  output logic              tag_ready,
  output logic              tag_empty,
  output logic              tag_error
);

  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e            state_q, state_d;
  logic              enabled_q;
  idx_t              init_cnt_q, init_cnt_d;
  idx_t              rd_ptr_q, rd_ptr_d;
  idx_t              wr_ptr_q, wr_ptr_d;
  logic [8:0]        free_count_q, free_count_d;
  logic [8:0]        in_flight_q, in_flight_d;
  logic [NUM_TAGS-1:0] busy_q, busy_d;
  command_tag_line_t resp_meta_q, resp_meta_d;
  logic              tag_error_q, tag_error_d;

  idx_t              fifo_mem [NUM_TAGS];
  command_tag_line_t tag_ram  [NUM_TAGS];

  logic ready;
  logic has_free;
  idx_t head;
  logic resp_fire;
  logic resp_in_range;
  idx_t resp_idx;
  logic resp_busy;
  logic retire;
  logic push;
  idx_t push_tag;

  function automatic idx_t ptr_inc(input idx_t p);
    return (p == idx_t'(NUM_TAGS - 1)) ? '0 : p + idx_t'(1);
  endfunction

  assign ready         = (state_q == ST_READY);
  assign has_free      = (free_count_q != 9'd0);
  assign head          = fifo_mem[rd_ptr_q];
  assign tag_alloc_gnt = tag_alloc_req & enabled_q & ready & has_free;
  assign tag_alloc_tag = has_free ? TAG_W'(head) : '0;

  // Tags beyond NUM_TAGS are never in flight and read back as zero metadata.
  assign resp_fire     = response_valid & enabled_q & ready;
  assign resp_in_range = ({1'b0, response_tag} < (TAG_W + 1)'(NUM_TAGS));
  assign resp_idx      = response_tag[IDX_W-1:0];
  assign resp_busy     = resp_in_range & busy_q[resp_idx];
  assign retire        = resp_fire & resp_busy & ~response_retain;

  assign push     = (state_q == ST_INIT) | retire;
  assign push_tag = (state_q == ST_INIT) ? init_cnt_q : resp_idx;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    free_count_d = free_count_q;
    in_flight_d  = in_flight_q;
    busy_d       = busy_q;
    resp_meta_d  = '0;
    tag_error_d  = 1'b0;

    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + idx_t'(1);
      if (init_cnt_q == idx_t'(NUM_TAGS - 1)) state_d = ST_READY;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (tag_alloc_gnt) rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case ({push, tag_alloc_gnt})
      2'b10:   free_count_d = free_count_q + 9'd1;
      2'b01:   free_count_d = free_count_q - 9'd1;
      default: free_count_d = free_count_q;
    endcase

    unique case ({tag_alloc_gnt, retire})
      2'b10:   in_flight_d = in_flight_q + 9'd1;
      2'b01:   in_flight_d = in_flight_q - 9'd1;
      default: in_flight_d = in_flight_q;
    endcase

    // The granted tag is always free, so it never collides with the retired one.
    if (tag_alloc_gnt) busy_d[head]     = 1'b1;
    if (retire)        busy_d[resp_idx] = 1'b0;

    if (resp_fire) begin
      resp_meta_d = resp_in_range ? tag_ram[resp_idx] : '0;
      tag_error_d = ~resp_busy;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_INIT;
      enabled_q    <= 1'b0;
      init_cnt_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      free_count_q <= '0;
      in_flight_q  <= '0;
      busy_q       <= '0;
      resp_meta_q  <= '0;
      tag_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      enabled_q    <= enabled_in;
      init_cnt_q   <= init_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      free_count_q <= free_count_d;
      in_flight_q  <= in_flight_d;
      busy_q       <= busy_d;
      resp_meta_q  <= resp_meta_d;
      tag_error_q  <= tag_error_d;
    end
  end

  // NOTE: the storage arrays carry no reset; pointers, count and the busy
  // bitmap decide which entries are meaningful, so they map onto plain RAM.
  always_ff @(posedge clock) begin
    if (push)          fifo_mem[wr_ptr_q] <= push_tag;
    if (tag_alloc_gnt) tag_ram[head]      <= tag_alloc_cmd;
  end

  assign response_tag_id_out = resp_meta_q;
  assign tags_in_flight      = in_flight_q;
  assign tag_ready           = ready;
  assign tag_empty           = ~has_free & ready;
  assign tag_error           = tag_error_q;

endmodule

// File: tb/tb_tag_control.sv
// Directed bench for tag_control: stimulus tasks queue expected grants and
// responses; a negedge monitor pops and compares them against the DUT.
module tb_tag_control;
  import tag_control_pkg::*;

  localparam int NT    = 32;
  localparam int TAG_W = 8;

  logic              clock = 1'b0;
  logic              rstn  = 1'b0;
  logic              enabled_in = 1'b0;
  logic              tag_alloc_req = 1'b0;
  command_tag_line_t tag_alloc_cmd = '0;
  logic              tag_alloc_gnt;
  logic [TAG_W-1:0]  tag_alloc_tag;
  logic              response_valid = 1'b0;
  logic [TAG_W-1:0]  response_tag = '0;
  logic              response_retain = 1'b0;
  command_tag_line_t response_tag_id_out;
  logic [8:0]        tags_in_flight;
  logic              tag_ready;
  logic              tag_empty;
  logic              tag_error;

  always #5 clock = ~clock;

  tag_control #(.NUM_TAGS(NT), .TAG_W(TAG_W)) dut (
    .clock               (clock),
    .rstn                (rstn),
    .enabled_in          (enabled_in),
    .tag_alloc_req       (tag_alloc_req),
    .tag_alloc_cmd       (tag_alloc_cmd),
    .tag_alloc_gnt       (tag_alloc_gnt),
    .tag_alloc_tag       (tag_alloc_tag),
    .response_valid      (response_valid),
    .response_tag        (response_tag),
    .response_retain     (response_retain),
    .response_tag_id_out (response_tag_id_out),
    .tags_in_flight      (tags_in_flight),
    .tag_ready           (tag_ready),
    .tag_empty           (tag_empty),
    .tag_error           (tag_error)
  );

  typedef struct {
    command_tag_line_t meta;
    logic              err;
  } resp_exp_t;

  int                checks   = 0;
  int                failures = 0;
  resp_exp_t         resp_q[$];
  int                gnt_q[$];
  int                free_model[$];
  command_tag_line_t ram_model [NT];
  bit                busy_model[NT];
  int                inflight_model = 0;
  bit                en_model = 1'b0;
  bit                ready_model = 1'b0;
  int                gen = 0;
  logic              resp_pend = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic command_tag_line_t make_meta(input int tag, input int g);
    command_tag_line_t m;
    m.com     = 13'(256 + tag);
    m.size    = 12'(g * 16 + tag);
    m.address = 64'h0000_0040_0000_0000 + 64'(tag * 128) + 64'(g) * 64'h1000;
    m.ctx     = 16'(40960 + g * 32 + tag);
    return m;
  endfunction

  task automatic reset_model();
    free_model.delete();
    for (int i = 0; i < NT; i++) busy_model[i] = 1'b0;
    inflight_model = 0;
    ready_model    = 1'b0;
  endtask

  task automatic fill_free_model();
    for (int i = 0; i < NT; i++) free_model.push_back(i);
    ready_model = 1'b1;
  endtask

  // Expect a grant this cycle of the oldest free tag.
  task automatic alloc_drive();
    int t;
    t = free_model.pop_front();
    gen++;
    tag_alloc_cmd     = make_meta(t, gen);
    ram_model[t]      = tag_alloc_cmd;
    busy_model[t]     = 1'b1;
    inflight_model++;
    gnt_q.push_back(t);
    tag_alloc_req = 1'b1;
  endtask

  task automatic respond_drive(input int tag, input bit retain);
    resp_exp_t e;
    bit live;
    live            = en_model && ready_model;
    response_valid  = 1'b1;
    response_tag    = TAG_W'(tag);
    response_retain = retain;
    e.meta = live ? ram_model[tag] : '0;
    e.err  = live && !busy_model[tag];
    resp_q.push_back(e);
    if (live && busy_model[tag] && !retain) begin
      busy_model[tag] = 1'b0;
      free_model.push_back(tag);
      inflight_model--;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    tag_alloc_req   = 1'b0;
    response_valid  = 1'b0;
    response_retain = 1'b0;
  endtask

  task automatic hold_req_no_grant(input int n);
    for (int i = 0; i < n; i++) begin
      tag_alloc_req = 1'b1;
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   128'(tag_alloc_gnt), 128'(0));
    check({tag, "_tag"},   128'(tag_alloc_tag), 128'(0));
    check({tag, "_meta"},  128'(response_tag_id_out), 128'(0));
    check({tag, "_count"}, 128'(tags_in_flight), 128'(0));
    check({tag, "_ready"}, 128'(tag_ready), 128'(0));
    check({tag, "_empty"}, 128'(tag_empty), 128'(0));
    check({tag, "_error"}, 128'(tag_error), 128'(0));
  endtask

  task automatic check_count(input string name);
    check(name, 128'(tags_in_flight), 128'(inflight_model));
  endtask

  // Monitor: grants are compared in the cycle they are presented, response
  // metadata and error one cycle after the response was driven.
  always @(negedge clock) begin
    if (!rstn) begin
      resp_pend = 1'b0;
    end else begin
      if (gnt_q.size() > 0) begin
        int exp_tag;
        exp_tag = gnt_q.pop_front();
        check("grant_present", 128'(tag_alloc_gnt), 128'(1));
        check("grant_tag", 128'(tag_alloc_tag), 128'(exp_tag));
      end else begin
        check("no_grant", 128'(tag_alloc_gnt), 128'(0));
      end
      if (resp_pend) begin
        if (resp_q.size() == 0) begin
          check("resp_queue_underflow", 128'(1), 128'(0));
        end else begin
          resp_exp_t e;
          e = resp_q.pop_front();
          check("resp_meta", 128'(response_tag_id_out), 128'(e.meta));
          check("resp_error", 128'(tag_error), 128'(e.err));
        end
      end else begin
        check("idle_meta", 128'(response_tag_id_out), 128'(0));
        check("idle_error", 128'(tag_error), 128'(0));
      end
      resp_pend = response_valid;
    end
  end

  initial begin
    reset_model();
    en_model      = 1'b1;
    enabled_in    = 1'b1;
    tag_alloc_req = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");

    // Initialisation: ready exactly 32 edges after release.
    rstn = 1'b1;
    for (int i = 1; i <= NT; i++) begin
      @(posedge clock);
      #1;
      if (i == NT - 1) check("ready_before_fill_done", 128'(tag_ready), 128'(0));
    end
    check("ready_after_fill", 128'(tag_ready), 128'(1));
    fill_free_model();

    // Back-to-back grants of tags 0..31.
    for (int i = 0; i < NT; i++) begin
      alloc_drive();
      step();
    end
    check_count("count_full");
    check("empty_full", 128'(tag_empty), 128'(1));
    hold_req_no_grant(3);
    check("empty_still_full", 128'(tag_empty), 128'(1));

    // Retire tag 5, then it is the next grant.
    respond_drive(5, 1'b0);
    step();
    check_count("count_after_retire5");
    check("empty_after_retire5", 128'(tag_empty), 128'(0));
    alloc_drive();
    step();
    check_count("count_after_regrant5");

    // Retained response keeps tag 5 in flight.
    respond_drive(5, 1'b1);
    step();
    check_count("count_after_retain5");
    hold_req_no_grant(2);
    check("empty_after_retain", 128'(tag_empty), 128'(1));

    // Full: request and retire in the same cycle gives no grant until next cycle.
    respond_drive(3, 1'b0);
    tag_alloc_req = 1'b1;
    step();
    check_count("count_same_cycle_full");
    alloc_drive();
    step();
    check_count("count_after_grant3");

    // Response to a tag that is no longer in flight.
    respond_drive(7, 1'b0);
    step();
    check_count("count_after_retire7");
    respond_drive(7, 1'b0);
    step();
    check_count("count_after_stale7");
    step();

    // Grant and retire together with a free tag available: net change zero.
    alloc_drive();
    respond_drive(9, 1'b0);
    step();
    check_count("count_alloc_and_retire");

    // Disabled: responses ignored, no grants, state held.
    enabled_in = 1'b0;
    step();
    en_model = 1'b0;
    respond_drive(5, 1'b0);
    tag_alloc_req = 1'b1;
    step();
    check_count("count_disabled");
    step();
    enabled_in = 1'b1;
    step();
    en_model = 1'b1;
    alloc_drive();
    step();
    check_count("count_after_reenable");

    // Reset mid-traffic, then a late response during INIT.
    tag_alloc_req = 1'b1;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    reset_model();
    step();
    step();
    rstn = 1'b1;
    respond_drive(5, 1'b0);
    tag_alloc_req = 1'b1;
    for (int i = 1; i <= NT; i++) begin
      @(posedge clock);
      #1;
      response_valid = 1'b0;
      if (i == NT - 1) check("ready_refill_before", 128'(tag_ready), 128'(0));
    end
    check("ready_refill_after", 128'(tag_ready), 128'(1));
    check_count("count_after_refill");
    fill_free_model();
    alloc_drive();
    step();
    check_count("count_first_after_refill");
    step();
    step();

    check("grant_queue_drained", 128'(gnt_q.size()), 128'(0));
    check("resp_queue_drained", 128'(resp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
